// File: rtl/hack_pc_sequencer.sv
// Hack CPU program-counter sequencer: fetches each instruction from ROM over a
// req/ack handshake, holds it for the datapath and applies the branch decision.
module hack_pc_sequencer #(
  parameter int                ADDR_W            = 15,
  parameter logic [ADDR_W-1:0] RESET_VECTOR      = {ADDR_W{1'b0}},
  parameter bit                HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              jump,
  input  logic [15:0]       a_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [31:0]       retired_q, retired_d;
  logic              rom_req_q, rom_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] target_s;
  logic              self_jump_s;
  logic              unused_a_reg_s;

  assign target_s       = a_reg[ADDR_W-1:0];
  assign unused_a_reg_s = ^a_reg;
  // The halt idiom keeps pc where it is, which loading the target already does.
  assign self_jump_s    = HALT_ON_SELF_JUMP && jump && (target_s == pc_q);

  // Next-state, PC, instruction latch and retire counter.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (rom_ack) begin
          instr_d = rom_data;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 32'd1;
          if (jump) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          if (self_jump_s) begin
            state_d = S_HALT;
          end else if (run) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Strobes are decoded from the next state so they are registered.
    rom_req_d     = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_EXEC);
    halted_d      = (state_d == S_HALT);
  end

  // State and output registers; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 16'h0000;
      retired_q     <= 32'd0;
      rom_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      rom_req_q     <= rom_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign rom_req     = rom_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign retired_cnt = retired_q;

endmodule

// File: doc/hack_pc_sequencer.md
Name: hack_pc_sequencer

Overview:
- Consumer end of the `jump` decision: holds the Hack program counter and sequences each instruction through fetch and execute.
- Fetches from instruction ROM with a req/ack handshake, presents the instruction to the CPU datapath, and waits for execute completion.
- On completion, applies the branch decision: PC loads the A-register target or increments.
- Detects the Hack halt idiom (unconditional jump to self) and counts retired instructions.

Parameters:
- ADDR_W, 15, PC / ROM address width.
- RESET_VECTOR, 0, PC value after reset.
- HALT_ON_SELF_JUMP, 1, 1 = a taken jump whose target equals the current PC enters HALTED.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable; sampled in IDLE and at instruction boundaries.
- rom_addr  out  ADDR_W  fetch address, equal to the PC.
- rom_req  out  1  fetch request; held until rom_ack.
- rom_ack  in  1  ROM data valid this cycle.
- rom_data  in  16  instruction word from ROM.
- instr  out  16  latched instruction presented to the datapath.
- instr_valid  out  1  high for the whole of EXECUTE.
- exec_done  in  1  datapath finished the instruction; jump and a_reg are valid this cycle.
- jump  in  1  branch-taken flag from the jump-condition block.
- a_reg  in  16  A register; bits [ADDR_W-1:0] form the branch target.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high in HALTED.
- retired_cnt  out  32  number of retired instructions.

Behaviour:
- Reset (async, rst_n=0) values:
  - pc=RESET_VECTOR, instr=0, retired_cnt=0.
  - rom_req=0, instr_valid=0, halted=0.
  - State IDLE.
  - A fetch in flight is abandoned; a late rom_ack after reset release is ignored in IDLE.
- States: IDLE, FETCH, EXECUTE, HALTED.
- IDLE:
  - All strobes low.
  - run=1 → FETCH next cycle; otherwise stay.
- FETCH:
  - rom_req=1, rom_addr=pc.
  - On rom_ack: instr<=rom_data, then EXECUTE next cycle; rom_req drops the same edge.
  - Minimum latency req→instr_valid is 1 cycle when rom_ack arrives in the first FETCH cycle.
  - run is ignored in FETCH; a fetch is never cancelled except by reset.
- EXECUTE:
  - instr_valid=1; instr stable.
  - Waits indefinitely for exec_done.
  - On exec_done, registered on the same edge:
    - retired_cnt += 1, wrapping at 2^32.
    - If jump=1: pc <= a_reg[ADDR_W-1:0].
    - If jump=0: pc <= pc+1, wrapping 2^ADDR_W-1 → 0.
  - Next state after exec_done:
    - HALTED, if HALT_ON_SELF_JUMP=1 and jump=1 and a_reg[ADDR_W-1:0]==pc. PC is unchanged; the instruction still counts as retired.
    - Otherwise FETCH if run=1, IDLE if run=0.
- HALTED:
  - halted=1, all other strobes low, pc frozen.
  - Exit only by reset; run has no effect.
- instr_valid is low in every state except EXECUTE; exec_done outside EXECUTE is ignored.
- jump and a_reg are sampled only on the exec_done cycle.
- rom_ack outside FETCH is ignored.
- All outputs are registered; no combinational input→output paths.

Test Plan:
- Sequential run:
  - Stimulus: reset, run=1; ROM acks after 2 cycles; exec_done 1 cycle after instr_valid; jump=0; 3 instructions.
  - Required: rom_addr 0,1,2; pc=3; retired_cnt=3; instr matches each rom_data.
- Taken branch:
  - Stimulus: at pc=5, exec_done with jump=1, a_reg=0x0123.
  - Required: next rom_addr=0x123, retired_cnt increments.
  - Repeat with jump=0, a_reg=0x0123: next rom_addr=6.
- Wrap-around:
  - Stimulus: pc=0x7FFF, exec_done, jump=0.
  - Required: pc=0x0000 and the next fetch addresses 0.
- Halt idiom:
  - Stimulus: pc=0x0010, exec_done, jump=1, a_reg=0x0010.
  - Required: halted=1 the next cycle, rom_req stays 0 for 20 cycles with run=1, retired_cnt counts the halt instruction.
  - Repeat with HALT_ON_SELF_JUMP=0: loops fetching 0x0010.
- Run gating:
  - Stimulus: drop run during EXECUTE.
  - Required: the instruction completes on exec_done, the FSM goes to IDLE with pc advanced; raising run resumes fetch from that pc.
  - Dropping run during FETCH does not cancel the request.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while rom_req=1, asynchronously between edges.
  - Required: rom_req and instr_valid go low immediately, pc=RESET_VECTOR, retired_cnt=0.
  - A stray rom_ack after release is ignored until run starts a new fetch.
